// File: rtl/fft8_pkg.sv
// fft8_pkg
//   Shared constants and types for the 8-point DIT FFT stage scheduler.
//   N_POINTS / ADDR_W  : transform size and sample address width
//   N_STAGES / N_BFLY  : 3 stages of 4 butterflies
//   sched_state_t      : scheduler FSM states
//   wr_slot_t          : one entry of the butterfly write-tracking pipeline
package fft8_pkg;

    localparam int N_POINTS = 8;
    localparam int ADDR_W   = 3;
    localparam int N_STAGES = 3;
    localparam int N_BFLY   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr_0;
        logic [ADDR_W-1:0] addr_1;
    } wr_slot_t;

endpackage

// File: rtl/fft8_addr_gen.sv
// fft8_addr_gen
//   Combinational butterfly address generator for a radix-2 DIT 8-point FFT.
//   Ports:
//     stage      in   2  stage 0..2
//     k          in   2  butterfly index within the stage 0..3
//     rd_addr_0  out  3  upper-leg operand address
//     rd_addr_1  out  3  lower-leg operand address (rd_addr_0 + span)
//     tw_idx     out  2  twiddle exponent k for W8^k
module fft8_addr_gen
    import fft8_pkg::*;
(
    input  logic [1:0]        stage,
    input  logic [1:0]        k,
    output logic [ADDR_W-1:0] rd_addr_0,
    output logic [ADDR_W-1:0] rd_addr_1,
    output logic [1:0]        tw_idx
);

    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] grp;
    logic [ADDR_W-1:0] pos;

    // NOTE: every output of this block is assigned on every pass, so no
    // latch can be inferred; keep it that way when adding terms.
    always_comb begin
        span      = ADDR_W'(1) << stage;
        grp       = {1'b0, k} >> stage;
        pos       = {1'b0, k} & (span - ADDR_W'(1));
        // grp * (2*span) is a shift by stage+1
        rd_addr_0 = (grp << (stage + 2'd1)) + pos;
        rd_addr_1 = rd_addr_0 + span;
        tw_idx    = pos[1:0] << (2'd2 - stage);
    end

endmodule

// File: rtl/fft8_stage_scheduler.sv
// fft8_stage_scheduler
//   Sequences a free-running radix-2 butterfly through an 8-point DIT FFT
//   (3 stages x 4 butterflies) using ping-pong sample banks.
//   Parameter:
//     BFLY_LAT  cycles from o_rd_en to butterfly output valid (1..4)
//   Ports:
//     i_clk, i_rst        clock; synchronous active-high reset
//     i_start             start request, sampled only in IDLE
//     i_hold              suppresses new issues; in-flight writes still retire
//     o_busy / o_done     busy from start acceptance through the done pulse
//     o_rd_en, o_rd_addr_0/1, o_tw_idx   butterfly issue
//     o_wr_en, o_wr_addr_0/1             result write, BFLY_LAT after issue
//     o_stage, o_bank_sel                current stage, bank being read
//   Optional feature (macro FFT_SCHED_PERF_EN):
//     o_cycle_cnt  8-bit count of cycles from start acceptance through done,
//                  saturating at 255, held until the next accepted start.
module fft8_stage_scheduler
    import fft8_pkg::*;
#(
    parameter int BFLY_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr_0,
    output logic [ADDR_W-1:0] o_rd_addr_1,
    output logic [1:0]        o_tw_idx,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr_0,
    output logic [ADDR_W-1:0] o_wr_addr_1,
    output logic [1:0]        o_stage,
    output logic              o_bank_sel
`ifdef FFT_SCHED_PERF_EN
    ,
    output logic [7:0]        o_cycle_cnt
`endif
);

    sched_state_t      state;
    logic [1:0]        k;
    logic [1:0]        stage_q;
    logic              bank_q;
    logic [2:0]        drain_cnt;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] last_addr_0;
    logic [ADDR_W-1:0] last_addr_1;
    logic [1:0]        last_tw;

    logic              issue;
    logic [ADDR_W-1:0] gen_addr_0;
    logic [ADDR_W-1:0] gen_addr_1;
    logic [1:0]        gen_tw;

    wr_slot_t          head;
    wr_slot_t          pipe [BFLY_LAT];

    fft8_addr_gen u_addr_gen (
        .stage     (stage_q),
        .k         (k),
        .rd_addr_0 (gen_addr_0),
        .rd_addr_1 (gen_addr_1),
        .tw_idx    (gen_tw)
    );

    // An issue happens in any ISSUE cycle that is not held; the operand
    // addresses are presented in that same cycle and otherwise show the
    // last issued pair so a stalled bus stays quiet.
    assign issue       = (state == ISSUE) && !i_hold;
    assign o_rd_en     = issue;
    assign o_rd_addr_0 = issue ? gen_addr_0 : last_addr_0;
    assign o_rd_addr_1 = issue ? gen_addr_1 : last_addr_1;
    assign o_tw_idx    = issue ? gen_tw     : last_tw;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_stage     = stage_q;
    assign o_bank_sel  = bank_q;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            k           <= '0;
            stage_q     <= '0;
            bank_q      <= 1'b0;
            drain_cnt   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_addr_0 <= '0;
            last_addr_1 <= '0;
            last_tw     <= '0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                last_addr_0 <= gen_addr_0;
                last_addr_1 <= gen_addr_1;
                last_tw     <= gen_tw;
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= ISSUE;
                        busy_q  <= 1'b1;
                        k       <= '0;
                        stage_q <= '0;
                        bank_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!i_hold) begin
                        k <= k + 2'd1;
                        if (k == 2'(N_BFLY - 1)) begin
                            state     <= DRAIN;
                            drain_cnt <= 3'(BFLY_LAT);
                        end
                    end
                end
                DRAIN: begin
                    // The last write of the stage retires in the final
                    // drain cycle, so the next stage may read it right after.
                    drain_cnt <= drain_cnt - 3'd1;
                    if (drain_cnt == 3'd1) begin
                        if (stage_q == 2'(N_STAGES - 1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            stage_q <= stage_q + 2'd1;
                            bank_q  <= ~bank_q;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write tracking: the butterfly is free-running, so this pipeline shifts
    // every cycle and ignores i_hold.
    assign head = issue ? '{valid: 1'b1, addr_0: gen_addr_0, addr_1: gen_addr_1}
                        : '0;

    // NOTE: the pipeline is reset even though it is a register array; a
    // stale valid bit here would emit a write after a mid-transform reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BFLY_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= head;
            for (int i = 1; i < BFLY_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign o_wr_en     = pipe[BFLY_LAT-1].valid;
    assign o_wr_addr_0 = pipe[BFLY_LAT-1].addr_0;
    assign o_wr_addr_1 = pipe[BFLY_LAT-1].addr_1;

`ifdef FFT_SCHED_PERF_EN
    logic [7:0] cycle_cnt;

    // The acceptance cycle counts as 1; every later busy cycle adds one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle_cnt <= '0;
        end else if (state == IDLE) begin
            if (i_start) begin
                cycle_cnt <= 8'd1;
            end
        end else if (cycle_cnt != 8'hFF) begin
            cycle_cnt <= cycle_cnt + 8'd1;
        end
    end

    assign o_cycle_cnt = cycle_cnt;
`endif

endmodule

// File: tb/tb_fft8_stage_scheduler.sv
// tb_fft8_stage_scheduler
//   Drives two scheduler instances (BFLY_LAT = 1 and 3) with identical
//   stimulus. A transaction-level model predicts issues, writes, done pulses
//   and busy per cycle into queues; a negedge monitor pops and compares.
module tb_fft8_stage_scheduler;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, hold;
    logic [1:0]      busy, done, rd_en, wr_en, bank;
    logic [1:0][2:0] rd_a0, rd_a1, wr_a0, wr_a1;
    logic [1:0][1:0] tw, stg;
`ifdef FFT_SCHED_PERF_EN
    logic [1:0][7:0] cyc_cnt;
`endif

    fft8_stage_scheduler #(.BFLY_LAT(LAT0)) u_lat1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_hold(hold),
        .o_busy(busy[0]), .o_done(done[0]), .o_rd_en(rd_en[0]),
        .o_rd_addr_0(rd_a0[0]), .o_rd_addr_1(rd_a1[0]), .o_tw_idx(tw[0]),
        .o_wr_en(wr_en[0]), .o_wr_addr_0(wr_a0[0]), .o_wr_addr_1(wr_a1[0]),
        .o_stage(stg[0]), .o_bank_sel(bank[0])
`ifdef FFT_SCHED_PERF_EN
        , .o_cycle_cnt(cyc_cnt[0])
`endif
    );

    fft8_stage_scheduler #(.BFLY_LAT(LAT1)) u_lat3 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_hold(hold),
        .o_busy(busy[1]), .o_done(done[1]), .o_rd_en(rd_en[1]),
        .o_rd_addr_0(rd_a0[1]), .o_rd_addr_1(rd_a1[1]), .o_tw_idx(tw[1]),
        .o_wr_en(wr_en[1]), .o_wr_addr_0(wr_a0[1]), .o_wr_addr_1(wr_a1[1]),
        .o_stage(stg[1]), .o_bank_sel(bank[1])
`ifdef FFT_SCHED_PERF_EN
        , .o_cycle_cnt(cyc_cnt[1])
`endif
    );

    typedef struct { int cyc; int a0; int a1; int tw; int stage; } rd_exp_t;
    typedef struct { int cyc; int a0; int a1; } wr_exp_t;

    rd_exp_t rd_q   [2][$];
    wr_exp_t wr_q   [2][$];
    int      done_q [2][$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Model state: mode 0 idle, 1 running, 2 done cycle.
    int m_mode   [2];
    int m_issued [2];
    int m_drain  [2];
    int m_start  [2];
    int m_len    [2];
    bit exp_busy [2];

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d cyc=%0d got=%0d want=%0d",
                     name, (d == 0) ? LAT0 : LAT1, cyc, act, exp);
        end
    endtask

    // Butterfly n (0..11) of the transform: stage n/4 pairs every index i
    // whose stage bit is clear with i+span, taken in ascending order of i.
    function automatic void pair_of(input int n, output int a0, output int a1,
                                    output int twi, output int s);
        int span, seen;
        s    = n / 4;
        span = 1 << s;
        seen = 0;
        a0   = 0;
        for (int i = 0; i < 8; i++) begin
            if ((i & span) == 0) begin
                if (seen == n % 4) a0 = i;
                seen++;
            end
        end
        a1  = a0 + span;
        twi = (a0 % span) * (4 / span);
    endfunction

    task automatic model_step(input int d, input int lat, input bit s,
                              input bit h, input bit r);
        int      nm;
        rd_exp_t re;
        wr_exp_t we;
        wr_exp_t keep [$];
        nm          = m_mode[d];
        exp_busy[d] = (m_mode[d] != 0);
        case (m_mode[d])
            0: if (s) begin
                nm          = 1;
                m_issued[d] = 0;
                m_drain[d]  = 0;
                m_start[d]  = cyc;
            end
            1: if (m_drain[d] > 0) begin
                m_drain[d]--;
                if (m_drain[d] == 0 && m_issued[d] == 12) nm = 2;
            end else if (!h) begin
                re.cyc = cyc;
                pair_of(m_issued[d], re.a0, re.a1, re.tw, re.stage);
                rd_q[d].push_back(re);
                we.cyc = cyc + lat; we.a0 = re.a0; we.a1 = re.a1;
                wr_q[d].push_back(we);
                m_issued[d]++;
                if (m_issued[d] % 4 == 0) m_drain[d] = lat;
            end
            default: begin
                done_q[d].push_back(cyc);
                m_len[d] = (cyc - m_start[d] + 1 > 255) ? 255 : cyc - m_start[d] + 1;
                nm       = 0;
            end
        endcase
        if (r) begin
            nm       = 0;
            m_len[d] = 0;
            for (int i = 0; i < wr_q[d].size(); i++) begin
                we = wr_q[d][i];
                if (we.cyc <= cyc) keep.push_back(we);
            end
            wr_q[d] = keep;
        end
        m_mode[d] = nm;
    endtask

    task automatic step(input bit s, input bit h, input bit r);
        start = s;
        hold  = h;
        rst   = r;
        model_step(0, LAT0, s, h, r);
        model_step(1, LAT1, s, h, r);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_busy"},  d, busy[d],  0);
            check({tag, "_done"},  d, done[d],  0);
            check({tag, "_rd_en"}, d, rd_en[d], 0);
            check({tag, "_rd_a"},  d, {rd_a0[d], rd_a1[d], tw[d]}, 0);
            check({tag, "_wr"},    d, {wr_en[d], wr_a0[d], wr_a1[d]}, 0);
            check({tag, "_stage"}, d, {stg[d], bank[d]}, 0);
`ifdef FFT_SCHED_PERF_EN
            check({tag, "_cnt"},   d, cyc_cnt[d], 0);
`endif
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef FFT_SCHED_PERF_EN
        for (int d = 0; d < 2; d++) check(tag, d, cyc_cnt[d], m_len[d]);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Monitor: compares every cycle's observed events with the model queues.
    rd_exp_t mre;
    wr_exp_t mwe;
    bit      e_rd, e_wr, e_dn;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                check("busy", d, busy[d], exp_busy[d]);

                e_rd = 1'b0;
                if (rd_q[d].size() > 0) begin
                    mre  = rd_q[d][0];
                    e_rd = (mre.cyc == cyc);
                end
                check("rd_en", d, rd_en[d], e_rd);
                if (e_rd) begin
                    void'(rd_q[d].pop_front());
                    if (rd_en[d]) begin
                        check("rd_addr", d, {rd_a0[d], rd_a1[d]}, {mre.a0[2:0], mre.a1[2:0]});
                        check("tw_idx",  d, tw[d],  mre.tw);
                        check("stage",   d, stg[d], mre.stage);
                        check("bank",    d, bank[d], mre.stage % 2);
                    end
                end

                e_wr = 1'b0;
                if (wr_q[d].size() > 0) begin
                    mwe  = wr_q[d][0];
                    e_wr = (mwe.cyc == cyc);
                end
                check("wr_en", d, wr_en[d], e_wr);
                if (e_wr) begin
                    void'(wr_q[d].pop_front());
                    if (wr_en[d])
                        check("wr_addr", d, {wr_a0[d], wr_a1[d]}, {mwe.a0[2:0], mwe.a1[2:0]});
                end

                e_dn = (done_q[d].size() > 0) && (done_q[d][0] == cyc);
                check("done", d, done[d], e_dn);
                if (e_dn) void'(done_q[d].pop_front());
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_issued[d] = 0; m_drain[d] = 0;
            m_start[d] = 0; m_len[d] = 0; exp_busy[d] = 1'b0;
        end
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(0, 0, 1);
        step(0, 0, 1);
        check_all_zero("reset");
        mon_en = 1'b1;
        step(0, 0, 0);

        // Plain transform, no hold
        step(1, 0, 0);
        for (int i = 0; i < 26; i++) step(0, 0, 0);
        check_perf("cnt_plain");
        step(0, 0, 0);
        check_perf("cnt_hold_value");

        // Hold 5 cycles mid-stage 1 plus start re-pulses while busy
        step(1, 0, 0);
        for (int i = 1; i < 34; i++) step(i == 3 || i == 15, i >= 8 && i <= 12, 0);
        check_perf("cnt_held");

        // Start held high and hold asserted with it: back-to-back transforms
        step(1, 1, 0);
        for (int i = 0; i < 60; i++) step(1, 0, 0);
        for (int i = 0; i < 26; i++) step(0, 0, 0);

        // Reset during stage 1, then a fresh full transform
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        step(0, 0, 1);
        check_all_zero("midrst");
        for (int i = 0; i < 25; i++) step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 26; i++) step(0, 0, 0);
        check_perf("cnt_after_rst");

        // Randomised start / hold / occasional reset
        for (int i = 0; i < 500; i++)
            step($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(99) == 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0);
        check_perf("cnt_random");

        for (int d = 0; d < 2; d++) begin
            check("rd_left",   d, rd_q[d].size(),   0);
            check("wr_left",   d, wr_q[d].size(),   0);
            check("done_left", d, done_q[d].size(), 0);
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fft8_stage_scheduler.md
Name: fft8_stage_scheduler

Overview:
Sequences the registered radix-2 butterfly unit through a full 8-point DIT FFT: 3 stages × 4 butterflies.
- Generates ping-pong buffer read/write address pairs, twiddle indices and bank select.
- Holds each stage boundary until the butterfly pipeline drains.
- Sits between the top-level start/done control and the sample buffers feeding the butterfly.

Parameters:
N_POINTS, 8, transform size; only 8 supported (3 stages, 4 butterflies/stage)
ADDR_W, 3, sample address width (log2 N_POINTS)
BFLY_LAT, 1, cycles from issue (o_rd_en) to butterfly output valid; legal 1..4

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; one clock; reset is synchronous and active-high
i_start  in  1  start-transform request; sampled only in IDLE
i_hold  in  1  stall request; suppresses new issues only
o_busy  out  1  high from start acceptance until the cycle o_done pulses (inclusive)
o_done  out  1  one-cycle pulse after the final write of stage 2
o_rd_en  out  1  issue strobe: butterfly operands read this cycle
o_rd_addr_0  out  ADDR_W  upper-leg operand address
o_rd_addr_1  out  ADDR_W  lower-leg operand address
o_tw_idx  out  2  twiddle index k for W8^k
o_wr_en  out  1  butterfly results valid; write to opposite bank
o_wr_addr_0  out  ADDR_W  destination of butterfly o_data_0
o_wr_addr_1  out  ADDR_W  destination of butterfly o_data_1
o_stage  out  2  current stage 0..2
o_bank_sel  out  1  bank read this stage; writes go to ~o_bank_sel

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; stage = 0; butterfly counter k = 0; write pipeline cleared.
- Reset mid-operation: returns to IDLE on the next edge and discards in-flight writes. No o_done is issued.
- FSM states and transitions:
  - IDLE: i_start=1 moves to ISSUE and sets o_busy at the next edge. i_start while busy is ignored.
  - ISSUE: when i_hold=0, asserts o_rd_en with addresses for (stage, k), then increments k. After k=3 is issued, moves to DRAIN.
  - ISSUE with i_hold=1: o_rd_en=0 and k is frozen. Outputs hold their last values.
  - DRAIN: waits BFLY_LAT cycles, during which the last writes retire.
    - If stage<2: increment stage, toggle bank_sel, k=0, return to ISSUE.
    - Otherwise go to DONE.
  - DONE: o_done=1 for one cycle with o_busy still 1, then IDLE. The next i_start is accepted in IDLE.
- Address generation, span = 1<<stage:
  - grp = k>>stage, pos = k & (span-1)
  - rd_addr_0 = grp*(2*span) + pos; rd_addr_1 = rd_addr_0 + span
  - tw_idx = pos << (2-stage)
- Write path:
  - Shift register of depth BFLY_LAT carrying {valid, addr_0, addr_1}.
  - o_wr_en / o_wr_addr_* appear exactly BFLY_LAT cycles after the matching o_rd_en.
  - The shift register advances every cycle regardless of i_hold; the butterfly is free-running.
- Timing: start sampled at cycle T, first issue at T+1. Each stage takes 4+BFLY_LAT cycles when unheld. o_done at T+3*(4+BFLY_LAT)+1, i.e. T+16 for BFLY_LAT=1. Each held cycle adds 1.
- Bank ping-pong: stage 0 reads bank 0, stage 1 reads bank 1, stage 2 reads bank 0. The final result lands in bank 1.
- Simultaneous events:
  - i_hold asserted in DRAIN has no effect.
  - i_start and i_hold together in IDLE: start is accepted, and the first issue waits until i_hold=0.

Optional Feature:
FFT_SCHED_PERF_EN
- Defined: adds output o_cycle_cnt (8 bits). It counts cycles from start acceptance to o_done inclusive, saturates at 255, and holds its value until the next accepted start. Reset value 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package fft8_pkg:
  - constants N_POINTS=8, ADDR_W=3, N_STAGES=3, N_BFLY=4
  - sched_state_t enum {IDLE, ISSUE, DRAIN, DONE}
  - wr_slot_t struct {valid, addr_0, addr_1}
- Sub-module fft8_addr_gen: purely combinational (stage, k) -> rd_addr_0, rd_addr_1, tw_idx. Shared by the issue path and the write pipeline input.

Test Plan:
- Reset, then i_start pulse at T, BFLY_LAT=1, no hold:
  - stage 0 rd pairs (0,1),(2,3),(4,5),(6,7), tw all 0
  - stage 1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2
  - stage 2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3
  - o_done at T+16
- Write tracking: every o_wr_en equals o_rd_en delayed BFLY_LAT cycles with identical address pair. Check with BFLY_LAT=1 and BFLY_LAT=3; for BFLY_LAT=3, o_done at T+22.
- i_hold high for 5 cycles mid-stage 1 after k=1: no o_rd_en during hold, k resumes at 2, in-flight write still retires, o_done delayed by exactly 5 cycles.
- i_start re-pulsed while busy: ignored, single o_done. i_start held high continuously: back-to-back transforms, IDLE one cycle between them.
- i_rst asserted during stage 1: next cycle all outputs 0, FSM IDLE, no o_wr_en afterwards, no o_done. A fresh start then yields the full sequence.
- With FFT_SCHED_PERF_EN: o_cycle_cnt=17 after the BFLY_LAT=1 unheld run and 22 with 5 hold cycles. The value holds until the next start.
